// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
// Shared constants for the raster timing generator: default 800x480 timing
// (928x525 totals), the derived sync window boundaries, coordinate widths
// and a helper that confirms a timing set fits the coordinate counters.
// Optional feature macro used by this block: VGA_TIMING_FRAME_CNT_EN.
// ---------------------------------------------------------------------------
package vga_timing_pkg;

  localparam int X_W = 11;
  localparam int Y_W = 10;

  localparam int H_ACTIVE_DEF = 800;
  localparam int H_FP_DEF     = 40;
  localparam int H_SYNC_DEF   = 48;
  localparam int H_BP_DEF     = 40;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 13;
  localparam int V_SYNC_DEF   = 3;
  localparam int V_BP_DEF     = 29;

  localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int HS_START_DEF = H_ACTIVE_DEF + H_FP_DEF;
  localparam int HS_END_DEF   = HS_START_DEF + H_SYNC_DEF;
  localparam int VS_START_DEF = V_ACTIVE_DEF + V_FP_DEF;
  localparam int VS_END_DEF   = VS_START_DEF + V_SYNC_DEF;

  // True when both totals can be counted by the X_W / Y_W counters.
  function automatic bit timing_fits(input int h_total, input int v_total);
    return (h_total <= (1 << X_W)) && (v_total <= (1 << Y_W));
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// ---------------------------------------------------------------------------
// vga_timing_gen_if
// Bundle of raster timing outputs delivered to the pixel pipeline / DAC.
//   hsync, vsync      : sync pulses (polarity set by the generator)
//   de                : active-region enable
//   x, y              : pixel coordinates, zero outside the active region
//   line_start        : one-cycle pulse at the first clock of each line
//   frame_start       : one-cycle pulse at the first clock of each frame
//   running           : synchronized PLL lock
//   frame_cnt         : frame counter (only with VGA_TIMING_FRAME_CNT_EN)
// Modports: master = generator side, slave = consumer side.
// ---------------------------------------------------------------------------
interface vga_timing_gen_if;
  import vga_timing_pkg::*;

  logic           hsync;
  logic           vsync;
  logic           de;
  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic           line_start;
  logic           frame_start;
  logic           running;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0]    frame_cnt;
`endif

  modport master (
    output hsync, vsync, de, x, y, line_start, frame_start, running
`ifdef VGA_TIMING_FRAME_CNT_EN
    , output frame_cnt
`endif
  );

  modport slave (
    input hsync, vsync, de, x, y, line_start, frame_start, running
`ifdef VGA_TIMING_FRAME_CNT_EN
    , input frame_cnt
`endif
  );

endinterface

// File: rtl/vga_timing_gen_sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Two-flop single-bit synchronizer for a level crossing into clk.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset (both flops clear to 0)
//   i_d   : asynchronous input level
//   o_q   : synchronized level, two clk edges of latency
// ---------------------------------------------------------------------------
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
// Raster timing generator clocked by the pixel PLL output. Waits for the
// synchronized PLL lock, then walks h/v counters over the full raster and
// decodes sync, data-enable, coordinates and line/frame strobes one clock
// after the counters. Losing lock zeroes the counters and parks all outputs
// at their reset values.
//   clk        : pixel clock
//   rst_n      : asynchronous active-low reset
//   pll_locked : PLL lock, asynchronous to clk
//   vga        : vga_timing_gen_if.master timing outputs
// Optional: define VGA_TIMING_FRAME_CNT_EN to add the 16-bit frame_cnt
// output, which counts frame_start events and holds while unlocked.
// ---------------------------------------------------------------------------
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE = H_ACTIVE_DEF,
  parameter int   H_FP     = H_FP_DEF,
  parameter int   H_SYNC   = H_SYNC_DEF,
  parameter int   H_BP     = H_BP_DEF,
  parameter int   V_ACTIVE = V_ACTIVE_DEF,
  parameter int   V_FP     = V_FP_DEF,
  parameter int   V_SYNC   = V_SYNC_DEF,
  parameter int   V_BP     = V_BP_DEF,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           pll_locked,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [X_W-1:0] H_LAST   = X_W'(H_TOTAL - 1);
  localparam logic [X_W-1:0] H_ACT    = X_W'(H_ACTIVE);
  localparam logic [X_W-1:0] HS_START = X_W'(H_ACTIVE + H_FP);
  localparam logic [X_W-1:0] HS_END   = X_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [Y_W-1:0] V_LAST   = Y_W'(V_TOTAL - 1);
  localparam logic [Y_W-1:0] V_ACT    = Y_W'(V_ACTIVE);
  localparam logic [Y_W-1:0] VS_START = Y_W'(V_ACTIVE + V_FP);
  localparam logic [Y_W-1:0] VS_END   = Y_W'(V_ACTIVE + V_FP + V_SYNC);

  if (!timing_fits(H_TOTAL, V_TOTAL)) begin : g_bad_timing
    $error("vga_timing_gen: raster totals exceed coordinate counter widths");
  end

  logic           w_lock_s;
  logic [X_W-1:0] r_h_cnt;
  logic [Y_W-1:0] r_v_cnt;

  logic           w_de;
  logic           w_hs_act;
  logic           w_vs_act;
  logic           w_line_start;
  logic           w_frame_start;

  logic           r_hsync;
  logic           r_vsync;
  logic           r_de;
  logic [X_W-1:0] r_x;
  logic [Y_W-1:0] r_y;
  logic           r_line_start;
  logic           r_frame_start;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (pll_locked),
    .o_q   (w_lock_s)
  );

  // Raster counters: held at the origin while unlocked so that re-lock
  // always restarts at the top-left pixel with a frame_start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (!w_lock_s) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (r_h_cnt == H_LAST) begin
      r_h_cnt <= '0;
      r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 1'b1;
    end else begin
      r_h_cnt <= r_h_cnt + 1'b1;
    end
  end

  always_comb begin
    w_de          = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
    w_hs_act      = (r_h_cnt >= HS_START) && (r_h_cnt < HS_END);
    // vsync decodes v_cnt only, so it moves on the same clock as line_start.
    w_vs_act      = (r_v_cnt >= VS_START) && (r_v_cnt < VS_END);
    w_line_start  = (r_h_cnt == '0);
    w_frame_start = (r_h_cnt == '0) && (r_v_cnt == '0);
  end

  // Registered decode, one clock behind the counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hsync       <= ~HS_POL;
      r_vsync       <= ~VS_POL;
      r_de          <= 1'b0;
      r_x           <= '0;
      r_y           <= '0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (!w_lock_s) begin
      r_hsync       <= ~HS_POL;
      r_vsync       <= ~VS_POL;
      r_de          <= 1'b0;
      r_x           <= '0;
      r_y           <= '0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_hsync       <= w_hs_act ? HS_POL : ~HS_POL;
      r_vsync       <= w_vs_act ? VS_POL : ~VS_POL;
      r_de          <= w_de;
      r_x           <= w_de ? r_h_cnt : '0;
      r_y           <= w_de ? r_v_cnt : '0;
      r_line_start  <= w_line_start;
      r_frame_start <= w_frame_start;
    end
  end

  assign vga.hsync       = r_hsync;
  assign vga.vsync       = r_vsync;
  assign vga.de          = r_de;
  assign vga.x           = r_x;
  assign vga.y           = r_y;
  assign vga.line_start  = r_line_start;
  assign vga.frame_start = r_frame_start;
  assign vga.running     = w_lock_s;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  // Steps on the edge that raises frame_start; keeps its value while
  // unlocked so software can see how many frames were produced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt <= '0;
    end else if (w_lock_s && w_frame_start) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign vga.frame_cnt = r_frame_cnt;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  // Reduced raster so complete frames fit in a short run.
  localparam int HA = 16, HFP = 4, HSY = 6, HBP = 4;
  localparam int VA = 12, VFP = 2, VSY = 3, VBP = 3;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam int FRAME = HT * VT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pll_locked = 1'b0;

  int checks = 0;
  int errors = 0;
  bit cont_en = 1'b0;

  vga_timing_gen_if vga ();

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .vga        (vga)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: lock is seen two edges late; while locked the output
  // state is a pure function of the clock count since the first locked edge.
  bit m_s1 = 1'b0, m_s2 = 1'b0, m_was;
  int m_pos = 0;
  int m_h, m_v;
  logic e_hs = 1'b1, e_vs = 1'b1, e_de = 1'b0, e_ls = 1'b0, e_fs = 1'b0, e_run = 1'b0;
  int e_x = 0, e_y = 0;
  logic [15:0] e_fcnt = 16'd0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 = 0; m_s2 = 0; m_pos = 0;
      e_hs = 1; e_vs = 1; e_de = 0; e_ls = 0; e_fs = 0; e_x = 0; e_y = 0;
      e_run = 0; e_fcnt = 0;
    end else begin
      m_was = m_s2;
      m_s2  = m_s1;
      m_s1  = pll_locked;
      e_run = m_s2;
      if (m_was) begin
        m_h  = m_pos % HT;
        m_v  = m_pos / HT;
        e_de = (m_h < HA) && (m_v < VA);
        e_hs = !((m_h >= HA + HFP) && (m_h < HA + HFP + HSY));
        e_vs = !((m_v >= VA + VFP) && (m_v < VA + VFP + VSY));
        e_x  = e_de ? m_h : 0;
        e_y  = e_de ? m_v : 0;
        e_ls = (m_h == 0);
        e_fs = (m_pos == 0);
        if (m_pos == 0) e_fcnt = e_fcnt + 16'd1;
        m_pos = (m_pos + 1) % FRAME;
      end else begin
        e_hs = 1; e_vs = 1; e_de = 0; e_ls = 0; e_fs = 0; e_x = 0; e_y = 0;
        m_pos = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (cont_en) begin
      check("hsync", vga.hsync, e_hs);
      check("vsync", vga.vsync, e_vs);
      check("de", vga.de, e_de);
      check("x", vga.x, e_x);
      check("y", vga.y, e_y);
      check("line_start", vga.line_start, e_ls);
      check("frame_start", vga.frame_start, e_fs);
      check("running", vga.running, e_run);
`ifdef VGA_TIMING_FRAME_CNT_EN
      check("frame_cnt", vga.frame_cnt, e_fcnt);
`endif
    end
  end

  task automatic check_idle(input string tag);
    check({tag, "_hsync"}, vga.hsync, 1);
    check({tag, "_vsync"}, vga.vsync, 1);
    check({tag, "_de"}, vga.de, 0);
    check({tag, "_x"}, vga.x, 0);
    check({tag, "_y"}, vga.y, 0);
    check({tag, "_ls"}, vga.line_start, 0);
    check({tag, "_fs"}, vga.frame_start, 0);
  endtask

  // Counts negedges until frame_start is seen, bounded.
  task automatic wait_fs(input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!vga.frame_start && n < limit);
  endtask

  initial begin
    int n;
    int last_ls, ls_min, ls_max, fs_second, de_cnt, lx, ly;
    int hs_start, hs_len, vs_first, vs_last, line;
    logic [15:0] fc_hold;

    // Reset, then a long unlocked interval.
    repeat (3) @(negedge clk);
    check_idle("reset");
    check("reset_running", vga.running, 0);
    #2 rst_n = 1'b1;
    cont_en = 1'b1;
    repeat (1000) @(negedge clk);
    check_idle("unlocked");
    check("unlocked_running", vga.running, 0);

    // Startup: lock sampled at edge k, outputs live after edge k+2.
    pll_locked = 1'b1;
    @(negedge clk);
    check("start_k_fs", vga.frame_start, 0);
    check("start_k_run", vga.running, 0);
    @(negedge clk);
    check("start_k1_run", vga.running, 1);
    check("start_k1_fs", vga.frame_start, 0);
    check("start_k1_de", vga.de, 0);
    @(negedge clk);
    check("start_k2_fs", vga.frame_start, 1);
    check("start_k2_ls", vga.line_start, 1);
    check("start_k2_de", vga.de, 1);
    check("start_k2_x", vga.x, 0);
    check("start_k2_y", vga.y, 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
    check("fcnt_first", vga.frame_cnt, 1);
`endif

    // Two full frames of raster measurements.
    last_ls = -1; ls_min = 1 << 30; ls_max = 0; fs_second = -1;
    de_cnt = 0; lx = -1; ly = -1; hs_start = -1; hs_len = 0;
    vs_first = -1; vs_last = -1; line = -1;
    for (int c = 0; c <= 2 * FRAME; c++) begin
      if (c > 0) @(negedge clk);
      if (vga.line_start) begin
        if (last_ls >= 0) begin
          if (c - last_ls < ls_min) ls_min = c - last_ls;
          if (c - last_ls > ls_max) ls_max = c - last_ls;
        end
        last_ls = c;
        line++;
      end
      if (vga.frame_start && c > 0 && fs_second < 0) fs_second = c;
`ifdef VGA_TIMING_FRAME_CNT_EN
      if (vga.frame_start && c == FRAME) check("fcnt_second", vga.frame_cnt, 2);
`endif
      if (c < FRAME) begin
        if (vga.de) begin de_cnt++; lx = int'(vga.x); ly = int'(vga.y); end
        if (line == 0 && !vga.hsync) begin
          if (hs_start < 0) hs_start = c;
          hs_len++;
        end
        if (vga.line_start && !vga.vsync) begin
          if (vs_first < 0) vs_first = line;
          vs_last = line;
        end
      end
    end
    check("ls_period_min", ls_min, HT);
    check("ls_period_max", ls_max, HT);
    check("fs_period", fs_second, FRAME);
    check("de_per_frame", de_cnt, HA * VA);
    check("last_x", lx, HA - 1);
    check("last_y", ly, VA - 1);
    check("hs_offset", hs_start, HA + HFP);
    check("hs_width", hs_len, HSY);
    check("vs_first_line", vs_first, VA + VFP);
    check("vs_last_line", vs_last, VA + VFP + VSY - 1);
`ifdef VGA_TIMING_FRAME_CNT_EN
    check("fcnt_third", vga.frame_cnt, 3);
`endif

    // Lose lock mid-line in the middle of the picture.
    n = 0;
    while (!(vga.de && vga.x == X_W'(HA / 2) && vga.y == Y_W'(VA / 2)) && n < FRAME + 10) begin
      @(negedge clk);
      n++;
    end
    check("drop_point_reached", n < FRAME + 10, 1);
`ifdef VGA_TIMING_FRAME_CNT_EN
    fc_hold = vga.frame_cnt;
`else
    fc_hold = 16'd0;
`endif
    pll_locked = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("drop");
    check("drop_running", vga.running, 0);
    repeat ($urandom_range(5, 50)) @(negedge clk);
`ifdef VGA_TIMING_FRAME_CNT_EN
    check("fcnt_held", vga.frame_cnt, fc_hold);
`endif
    pll_locked = 1'b1;
    wait_fs(FRAME, n);
    check("relock_latency", n, 3);
    check("relock_x", vga.x, 0);
    check("relock_y", vga.y, 0);
    check("relock_de", vga.de, 1);

`ifdef VGA_TIMING_FRAME_CNT_EN
    // Wrap of the frame counter.
    repeat (5) @(negedge clk);
    force dut.r_frame_cnt = 16'hFFFF;
    e_fcnt = 16'hFFFF;
    @(negedge clk);
    release dut.r_frame_cnt;
    wait_fs(FRAME + 10, n);
    check("fcnt_wrap", vga.frame_cnt, 0);
`endif

    // Random lock glitches of varying lengths; the model tracks every cycle.
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(1, FRAME)) @(negedge clk);
      pll_locked = 1'b0;
      repeat ($urandom_range(1, 8)) @(negedge clk);
      pll_locked = 1'b1;
    end
    repeat ($urandom_range(HT, FRAME)) @(negedge clk);

    // Asynchronous reset mid-frame, observed before any further clock edge.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_idle("async_rst");
    check("async_rst_running", vga.running, 0);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b1;
    wait_fs(FRAME, n);
    check("rst_restart_latency", n, 3);
    check("rst_restart_ls", vga.line_start, 1);
    check("rst_restart_x", vga.x, 0);
    check("rst_restart_y", vga.y, 0);
    repeat (2 * HT) @(negedge clk);

    cont_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
